// File: rtl/dp_stream_loader.sv
// Memory-to-stream loader: Avalon-MM read master filling a FWFT FIFO drained on a valid/ready port.
// Word returned at edge k appears on st_data after k; reads stop while fifo_level + outstanding reaches DEPTH.

// Generic first-word-fall-through FIFO; head is visible the cycle after the push edge.
// Push when full and pop when empty are dropped; clear empties it and wins over push.
module stream_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign empty    = (count == '0);
  assign level    = count;
  assign head_dat = mem[rd_ptr];
  assign do_push  = push && (count != FULL_C) && !clear;
  assign do_pop   = pop && !empty && !clear;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end
endmodule

// Register slave + read-request FSM + FIFO; slave reads are combinational.
// Stream backpressure stalls the FIFO, which in turn throttles new read requests.
module dp_stream_loader #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic [31:0] st_data,
  output logic        st_valid,
  input  logic        st_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]      CAP_C   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]    OUT_ONE = CW'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE, S_FLUSH} state_t;
  state_t state, state_nxt;

  logic [31:0]      base_reg, addr_ptr, delivered;
  logic [LEN_W-1:0] length_reg, remaining;
  logic [CW-1:0]    outstanding, fifo_level;
  logic [CW:0]      committed;
  logic [31:0]      fifo_head;
  logic             fifo_empty, done_reg, hold_req;
  logic             busy, flush;
  logic             wr_base, wr_len, start_cmd, abort_cmd;
  logic             req_accept, ret_vld, push, pop;

  // Slave command decode; BASE/LENGTH are frozen while a transfer is active.
  assign wr_base   = wr_en && (addr == 2'd0) && !busy;
  assign wr_len    = wr_en && (addr == 2'd1) && !busy;
  assign abort_cmd = wr_en && (addr == 2'd2) && dataIn[1] &&
                     ((state == S_FETCH) || (state == S_DRAIN));
  assign start_cmd = wr_en && (addr == 2'd2) && dataIn[0] && !dataIn[1] &&
                     (state == S_IDLE);

  assign committed  = {1'b0, fifo_level} + {1'b0, outstanding};
  assign req_accept = m_read && !m_waitrequest;
  // Returns with nothing outstanding belong to a transfer killed by reset.
  assign ret_vld    = m_readdatavalid && (outstanding != '0);
  assign push       = ret_vld && !flush;
  assign pop        = st_valid && st_ready;
  assign st_valid   = !fifo_empty && !flush;
  assign st_data    = st_valid ? fifo_head : 32'd0;
  assign m_address  = addr_ptr;

  stream_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (flush),
    .push     (push),
    .push_dat (m_readdata),
    .pop      (pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_cmd) state_nxt = (length_reg == '0) ? S_DONE : S_FETCH;
      S_FETCH: begin
        if (abort_cmd)               state_nxt = S_FLUSH;
        else if (remaining == '0)    state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_cmd)                                 state_nxt = S_FLUSH;
        else if ((outstanding == '0) && fifo_empty)    state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_FLUSH: if ((outstanding == '0) && !hold_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A request stalled when ABORT lands must still complete, so FLUSH replays it via hold_req.
  always_comb begin
    busy   = (state != S_IDLE);
    flush  = (state == S_FLUSH);
    m_read = 1'b0;
    case (state)
      S_FETCH: m_read = (remaining != '0) && (committed < CAP_C);
      S_FLUSH: m_read = hold_req;
      default: m_read = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_reg   <= '0;
      length_reg <= '0;
    end else begin
      if (wr_base) base_reg   <= {dataIn[31:2], 2'b00};
      if (wr_len)  length_reg <= dataIn[LEN_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_ptr    <= '0;
      remaining   <= '0;
      outstanding <= '0;
      hold_req    <= 1'b0;
    end else begin
      hold_req <= m_read && m_waitrequest;
      if (start_cmd) begin
        addr_ptr  <= base_reg;
        remaining <= length_reg;
      end else if (req_accept) begin
        addr_ptr <= addr_ptr + 32'd4;
        if (remaining != '0) remaining <= remaining - LEN_ONE;
      end
      case ({req_accept, ret_vld})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_reg  <= 1'b0;
      delivered <= '0;
    end else begin
      if (start_cmd)             done_reg <= 1'b0;
      else if (state == S_DONE)  done_reg <= 1'b1;
      if (start_cmd)                      delivered <= '0;
      else if (pop && (delivered != '1))  delivered <= delivered + 32'd1;
    end
  end

  always_comb begin
    dataOut = 32'd0;
    if (rd_en) begin
      case (addr)
        2'd0:    dataOut = base_reg;
        2'd1:    dataOut = 32'(length_reg);
        2'd2:    dataOut = {16'd0, 8'(fifo_level), 6'd0, done_reg, busy};
        default: dataOut = delivered;
      endcase
    end
  end
endmodule

// File: doc/dp_stream_loader.md
# dp_stream_loader

Memory-to-stream loader that sits directly upstream of the dot-product accelerator. Software programs a base address and word count through a small memory-mapped register slave. The block then reads those words from system memory over a pipelined Avalon-MM read master and buffers them in an internal FIFO. It presents them on a valid/ready stream that the accelerator consumes one 32-bit operand per beat.

## Interface
- DEPTH, 8, FIFO depth in words (power of 2, 4..64); also the cap on reads in flight plus buffered words
- LEN_W, 16, width of the LENGTH register (max words per transfer = 2^LEN_W - 1)
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- addr  in  2  slave register select
- rd_en  in  1  slave read strobe
- wr_en  in  1  slave write strobe
- dataIn  in  32  slave write data
- dataOut  out  32  slave read data, combinational from addr/rd_en; 0 when rd_en=0
- m_address  out  32  master byte address
- m_read  out  1  master read request
- m_waitrequest  in  1  master stall; request held while high
- m_readdata  in  32  master return data
- m_readdatavalid  in  1  return data valid
- st_data  out  32  stream word to accelerator
- st_valid  out  1  st_data valid
- st_ready  in  1  accelerator accepts word when st_valid & st_ready

## Operation
- Registers:
  - addr 0 BASE (RW): bits [1:0] forced 0.
  - addr 1 LENGTH (RW): low LEN_W bits; upper bits read 0.
  - addr 2 CTRL/STATUS: write bit0=START, bit1=ABORT. Read bit0=BUSY, bit1=DONE (sticky), bits [15:8]=FIFO level.
  - addr 3 DELIVERED (RO): words accepted on stream since last START.
- Writes to BASE/LENGTH while BUSY are ignored. START while BUSY is ignored. ABORT while IDLE is ignored. START and ABORT in the same write: ABORT wins.
- FSM:
  - IDLE: on START, latch addr_ptr=BASE and remaining=LENGTH; clear DONE and DELIVERED.
    - LENGTH=0: go to DONE.
    - Otherwise: go to FETCH.
  - FETCH: request reads.
    - Issue when remaining>0 and (fifo_level + outstanding) < DEPTH.
    - Each accepted request (m_read & !m_waitrequest): addr_ptr += 4 (wraps at 2^32), remaining -= 1, outstanding += 1.
    - When remaining=0: go to DRAIN.
  - DRAIN: wait until outstanding=0 and FIFO empty, then go to DONE.
  - DONE: set DONE=1 for one state cycle, then go to IDLE.
  - ABORT (from FETCH or DRAIN): go to FLUSH.
    - Stop new requests. A request currently stalled by waitrequest is held until accepted, then counted as outstanding.
    - Returning data is discarded. FIFO is cleared. st_valid=0.
    - When outstanding=0, go to IDLE with DONE=0.
- BUSY = state is not IDLE.
- Returned data (m_readdatavalid) is pushed into the FIFO in order. The FIFO never overflows, by construction.
- FIFO push and pop in the same cycle are both honoured; the level is unchanged.
- st_valid = FIFO not empty (outside FLUSH). st_data = FIFO head.
- DELIVERED increments on each stream handshake and saturates at all ones.

## Timing
- Reset: state IDLE; BASE=LENGTH=DELIVERED=0; DONE=0; FIFO empty; outstanding=0.
- Reset outputs: m_read=0, m_address=0, st_valid=0, st_data=0, dataOut=0.
- Reset asserted mid-transfer aborts immediately with the same values. In-flight returns after reset release are ignored, because outstanding=0.
- START written at edge T: BUSY reads 1 from T+1; m_read=1 with m_address=BASE from T+1.
- While m_waitrequest=1, m_read and m_address are held stable.
- Back-to-back requests issue one per cycle when space allows.
- m_readdatavalid at edge k: the word is visible on st_data with st_valid=1 after edge k (first-word fall-through, 1 cycle).
- Last stream handshake at edge j with outstanding=0: DRAIN→DONE at j+1, DONE→IDLE at j+2.
- DONE reads 1 from j+2 and stays set until the next START. BUSY reads 0 from j+2.
- Slave reads are zero-wait-state and combinational in the same cycle.

## Test plan
- Reset/idle: assert reset_n=0 mid-FETCH → m_read=0, st_valid=0, all registers 0; read addr 2 → 0.
- Basic transfer: BASE=0x1000, LENGTH=5, memory returns 0xA0..0xA4 at latency 2, st_ready=1.
  - Addresses 0x1000..0x1010 issued back-to-back.
  - Stream words 0xA0..0xA4 emitted in order.
  - DELIVERED=5; STATUS=0x2 after completion.
- Backpressure: LENGTH=20, DEPTH=8, st_ready=0 → at most 8 requests issued and FIFO level reads 8. Then st_ready=1 → all 20 words delivered in order with no loss or duplication.
- Waitrequest stall: m_waitrequest high 3 cycles on the 2nd request → m_address holds 0x1004 for 3 cycles; the transfer completes correctly.
- Abort: ABORT after 3 of 10 words delivered, with 2 reads outstanding → both returns discarded, st_valid=0, BUSY drops once outstanding=0, DONE=0, DELIVERED=3.
- Boundaries:
  - LENGTH=0 START → no m_read, DONE=1 two cycles later.
  - BASE=0xFFFFFFFC, LENGTH=2 → addresses 0xFFFFFFFC then 0x00000000.
  - BASE write 0x1003 reads back 0x1000.
  - BASE write while BUSY is ignored.
